// File: rtl/antiring_multi.sv
// Multi-channel anti-chatter RS latch: 2-flop sync, consecutive-low
// filter per input, registered latch with edge pulses and conflict flag.
module antiring_multi #(
  parameter int CHANNELS = 4,
  parameter int SET_LEN  = 8,
  parameter int RST_LEN  = 8,
  parameter int MODE     = 0,
  parameter bit INIT_Q   = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] s_n,
  input  logic [CHANNELS-1:0] r_n,
  output logic [CHANNELS-1:0] q,
  output logic [CHANNELS-1:0] q_rise,
  output logic [CHANNELS-1:0] q_fall,
  output logic [CHANNELS-1:0] conflict
);

  localparam int SW = $clog2(SET_LEN + 1);
  localparam int RW = $clog2(RST_LEN + 1);
  localparam logic [SW-1:0] SMAX = SW'(SET_LEN);
  localparam logic [RW-1:0] RMAX = RW'(RST_LEN);

  logic [CHANNELS-1:0] s_meta_q, s_sync_q;
  logic [CHANNELS-1:0] r_meta_q, r_sync_q;
  logic [SW-1:0]       s_cnt_q [CHANNELS];
  logic [SW-1:0]       s_cnt_d [CHANNELS];
  logic [RW-1:0]       r_cnt_q [CHANNELS];
  logic [RW-1:0]       r_cnt_d [CHANNELS];
  logic [CHANNELS-1:0] s_act, r_act;
  logic [CHANNELS-1:0] q_q, q_d;
  logic [CHANNELS-1:0] qprev_q;
  logic [CHANNELS-1:0] rise_q, fall_q;
  logic [CHANNELS-1:0] conf_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      s_act[i] = (s_cnt_q[i] == SMAX);
      r_act[i] = (r_cnt_q[i] == RMAX);
      if (s_sync_q[i])
        s_cnt_d[i] = '0;
      else if (!s_act[i])
        s_cnt_d[i] = s_cnt_q[i] + SW'(1);
      else
        s_cnt_d[i] = s_cnt_q[i];
      if (r_sync_q[i])
        r_cnt_d[i] = '0;
      else if (!r_act[i])
        r_cnt_d[i] = r_cnt_q[i] + RW'(1);
      else
        r_cnt_d[i] = r_cnt_q[i];
    end
  end

  // Dominance when both requests are qualified is fixed by MODE.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case ({s_act[i], r_act[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11: begin
          if (MODE == 0)      q_d[i] = 1'b0;
          else if (MODE == 1) q_d[i] = 1'b1;
          else                q_d[i] = q_q[i];
        end
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s_meta_q <= '1;
      s_sync_q <= '1;
      r_meta_q <= '1;
      r_sync_q <= '1;
      for (int i = 0; i < CHANNELS; i++) begin
        s_cnt_q[i] <= '0;
        r_cnt_q[i] <= '0;
      end
      q_q     <= {CHANNELS{INIT_Q}};
      qprev_q <= {CHANNELS{INIT_Q}};
      rise_q  <= '0;
      fall_q  <= '0;
      conf_q  <= '0;
    end else begin
      s_meta_q <= s_n;
      s_sync_q <= s_meta_q;
      r_meta_q <= r_n;
      r_sync_q <= r_meta_q;
      for (int i = 0; i < CHANNELS; i++) begin
        s_cnt_q[i] <= s_cnt_d[i];
        r_cnt_q[i] <= r_cnt_d[i];
      end
      q_q     <= q_d;
      qprev_q <= q_q;
      rise_q  <= q_q & ~qprev_q;
      fall_q  <= ~q_q & qprev_q;
      conf_q  <= s_act & r_act;
    end
  end

  assign q        = q_q;
  assign q_rise   = rise_q;
  assign q_fall   = fall_q;
  assign conflict = conf_q;

endmodule
